// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game phase FSM with lives/score/wave and gated move/bullet ticks (optional HIGH_SCORE_EN)
module game_sequencer #(
  parameter int LIVES_INIT   = 3,
  parameter int SCORE_W      = 14,
  parameter int WAVE_W       = 4,
  parameter int WAVE_MAX     = 9,
  parameter int MOVE_DIV     = 1666666,
  parameter int BULLET_DIV   = 4,
  parameter int DYING_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               player_hit,
  input  logic               enemy_killed,
  input  logic               wave_clear,
  output logic [2:0]         state,
  output logic               play_en,
  output logic               move_tick,
  output logic               bullet_tick,
  output logic               respawn,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [WAVE_W-1:0]  wave
`ifdef HIGH_SCORE_EN
  ,
  output logic [SCORE_W-1:0] hi_score
`endif
);

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int BW = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
  localparam int DW = (DYING_CYCLES > 1) ? $clog2(DYING_CYCLES) : 1;

  localparam logic [MW-1:0]     MOVE_LAST   = MW'(MOVE_DIV - 1);
  localparam logic [BW-1:0]     BULLET_LAST = BW'(BULLET_DIV - 1);
  localparam logic [DW-1:0]     DYING_LAST  = DW'(DYING_CYCLES - 1);
  localparam logic [WAVE_W-1:0] WAVE_TOP    = WAVE_W'(WAVE_MAX);
  localparam logic [WAVE_W-1:0] WAVE_ONE    = WAVE_W'(1);
  localparam logic [2:0]        LIVES_LOAD  = 3'(LIVES_INIT);

  typedef enum logic [2:0] {
    S_ATTRACT = 3'd0,
    S_PLAY    = 3'd1,
    S_PAUSE   = 3'd2,
    S_DYING   = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic start_prev, pause_prev;
  logic start_press, pause_press;
  logic load_game, score_inc, wave_inc, respawn_d;

  logic [MW-1:0] move_cnt;
  logic [BW-1:0] bullet_cnt;
  logic [DW-1:0] dying_cnt;

  // Button history; it follows the level even during rst so a button held through reset is not a press
  always_ff @(posedge clk) begin
    start_prev <= start_btn;
    pause_prev <= pause_btn;
  end

  assign start_press = start_btn & ~start_prev;
  assign pause_press = pause_btn & ~pause_prev;

  // Next-state and per-cycle game events; hit outranks pause in PLAY
  always_comb begin
    state_d   = state_q;
    load_game = 1'b0;
    score_inc = 1'b0;
    wave_inc  = 1'b0;
    respawn_d = 1'b0;
    case (state_q)
      S_ATTRACT: begin
        if (start_press) begin
          state_d   = S_PLAY;
          load_game = 1'b1;
          respawn_d = 1'b1;
        end
      end
      S_PLAY: begin
        score_inc = enemy_killed;
        wave_inc  = wave_clear;
        respawn_d = wave_clear;
        if (player_hit) begin
          state_d = S_DYING;
        end else if (pause_press) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_press) begin
          state_d = S_PLAY;
        end
      end
      S_DYING: begin
        if (dying_cnt == DYING_LAST) begin
          if (lives != 3'd0) begin
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end else begin
            state_d = S_OVER;
          end
        end
      end
      S_OVER: begin
        if (start_press) begin
          state_d = S_ATTRACT;
        end
      end
      default: state_d = S_ATTRACT;
    endcase
  end

  // State register plus registered play_en and respawn pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ATTRACT;
      play_en <= 1'b0;
      respawn <= 1'b0;
    end else begin
      state_q <= state_d;
      play_en <= (state_d == S_PLAY);
      respawn <= respawn_d;
    end
  end

  assign state = state_q;

  // Lives, saturating score and wrapping 1-based wave
  always_ff @(posedge clk) begin
    if (rst) begin
      lives <= 3'd0;
      score <= '0;
      wave  <= WAVE_ONE;
    end else begin
      if (load_game) begin
        lives <= LIVES_LOAD;
      end else if (state_q == S_PLAY && player_hit && lives != 3'd0) begin
        lives <= lives - 3'd1;
      end
      if (load_game) begin
        score <= '0;
      end else if (score_inc && !(&score)) begin
        score <= score + 1'b1;
      end
      if (load_game) begin
        wave <= WAVE_ONE;
      end else if (wave_inc) begin
        wave <= (wave == WAVE_TOP) ? WAVE_ONE : wave + 1'b1;
      end
    end
  end

  // DYING dwell counter, idle at zero outside DYING
  always_ff @(posedge clk) begin
    if (rst) begin
      dying_cnt <= '0;
    end else if (state_q == S_DYING) begin
      dying_cnt <= dying_cnt + 1'b1;
    end else begin
      dying_cnt <= '0;
    end
  end

  // Move/bullet prescalers: run in PLAY, hold in PAUSE, and a wrap that would land outside PLAY waits at the last count
  always_ff @(posedge clk) begin
    if (rst) begin
      move_cnt    <= '0;
      bullet_cnt  <= '0;
      move_tick   <= 1'b0;
      bullet_tick <= 1'b0;
    end else begin
      move_tick   <= 1'b0;
      bullet_tick <= 1'b0;
      if (state_d == S_PLAY && state_q != S_PLAY && state_q != S_PAUSE) begin
        move_cnt   <= '0;
        bullet_cnt <= '0;
      end else if (state_q == S_PLAY) begin
        if (move_cnt != MOVE_LAST) begin
          move_cnt <= move_cnt + 1'b1;
        end else if (state_d == S_PLAY) begin
          move_cnt  <= '0;
          move_tick <= 1'b1;
          if (bullet_cnt == BULLET_LAST) begin
            bullet_cnt  <= '0;
            bullet_tick <= 1'b1;
          end else begin
            bullet_cnt <= bullet_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef HIGH_SCORE_EN
  // Best score so far, captured when a game ends
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_score <= '0;
    end else if (state_d == S_OVER && state_q != S_OVER && score > hi_score) begin
      hi_score <= score;
    end
  end
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer
module tb_game_sequencer;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst, start_btn, pause_btn, player_hit, enemy_killed, wave_clear;
  logic [2:0] state;
  logic play_en, move_tick, bullet_tick, respawn;
  logic [2:0] lives;
  logic [SW-1:0] score;
  logic [3:0] wave;
`ifdef HIGH_SCORE_EN
  logic [SW-1:0] hi_score;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;
  exp_t exp_q[$];

  game_sequencer #(
    .LIVES_INIT(2), .SCORE_W(SW), .WAVE_W(4), .WAVE_MAX(3),
    .MOVE_DIV(4), .BULLET_DIV(2), .DYING_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .player_hit(player_hit), .enemy_killed(enemy_killed), .wave_clear(wave_clear),
    .state(state), .play_en(play_en), .move_tick(move_tick), .bullet_tick(bullet_tick),
    .respawn(respawn), .lives(lives), .score(score), .wave(wave)
`ifdef HIGH_SCORE_EN
    , .hi_score(hi_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [2:0] s, input logic [2:0] l,
                      input logic [SW-1:0] sc, input logic [3:0] w);
    exp_t e;
    e.name = n;
    e.v = {s, l, sc, w};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_btn = 1'b1; pause_btn = 1'b0;
    player_hit = 1'b0; enemy_killed = 1'b0; wave_clear = 1'b0;
    push("reset", 3'd0, 3'd0, 3'd0, 4'd1);
    repeat (3) step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    checks++;
    if ({play_en, move_tick, bullet_tick, respawn} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000", {play_en, move_tick, bullet_tick, respawn});
    end
`ifdef HIGH_SCORE_EN
    checks++;
    if (hi_score !== '0) begin errors++; $display("FAIL reset_hi got=%0d exp=0", hi_score); end
`endif
    rst = 1'b0;
    push("held_start", 3'd0, 3'd0, 3'd0, 4'd1);
    repeat (5) step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
  endtask

  task automatic test_start();
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    push("start", 3'd1, 3'd2, 3'd0, 4'd1);
    step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    checks++;
    if (respawn !== 1'b1 || play_en !== 1'b1) begin
      errors++; $display("FAIL start_pulse respawn=%b play_en=%b exp=1 1", respawn, play_en);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (move_tick !== (k % 4 == 0) || bullet_tick !== (k % 8 == 0) || respawn !== 1'b0) begin
        errors++;
        $display("FAIL start_ticks k=%0d got mt=%b bt=%b rs=%b exp mt=%b bt=%b rs=0",
                 k, move_tick, bullet_tick, respawn, (k % 4 == 0), (k % 8 == 0));
      end
    end
  endtask

  task automatic test_pause();
    step();
    pause_btn = 1'b1;
    push("pause", 3'd2, 3'd2, 3'd0, 4'd1);
    step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    pause_btn = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      checks++;
      if (move_tick !== 1'b0 || bullet_tick !== 1'b0 || play_en !== 1'b0 || state !== 3'd2) begin
        errors++;
        $display("FAIL pause_freeze k=%0d got mt=%b bt=%b pe=%b st=%0d exp 0 0 0 2", k, move_tick, bullet_tick, play_en, state);
      end
    end
    pause_btn = 1'b1;
    push("resume", 3'd1, 3'd2, 3'd0, 4'd1);
    step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    step();
    checks++;
    if (move_tick !== 1'b0) begin errors++; $display("FAIL resume_early got=%b exp=0", move_tick); end
    step();
    checks++;
    if (move_tick !== 1'b1 || bullet_tick !== 1'b0) begin
      errors++; $display("FAIL resume_tick got mt=%b bt=%b exp mt=1 bt=0", move_tick, bullet_tick);
    end
    pause_btn = 1'b0;
  endtask

  task automatic test_priority();
    step();
    player_hit = 1'b1; enemy_killed = 1'b1; pause_btn = 1'b1;
    push("hit_prio", 3'd3, 3'd1, 3'd1, 4'd1);
    step();
    player_hit = 1'b0; enemy_killed = 1'b0;
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    checks++;
    if (play_en !== 1'b0) begin errors++; $display("FAIL dying_play_en got=%b exp=0", play_en); end
    repeat (3) step();
    enemy_killed = 1'b1;
    step();
    enemy_killed = 1'b0;
    push("dying_hold", 3'd3, 3'd1, 3'd1, 4'd1);
    repeat (3) step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    push("respawn_play", 3'd1, 3'd1, 3'd1, 4'd1);
    step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    checks++;
    if (respawn !== 1'b1) begin errors++; $display("FAIL dying_respawn got=%b exp=1", respawn); end
    pause_btn = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (move_tick !== (k == 4) || respawn !== 1'b0) begin
        errors++; $display("FAIL respawn_ticks k=%0d got mt=%b rs=%b exp mt=%b rs=0", k, move_tick, respawn, (k == 4));
      end
    end
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 4; i++) begin
      enemy_killed = 1'b1;
      step();
    end
    enemy_killed = 1'b0;
    push("kills", 3'd1, 3'd1, 3'd5, 4'd1);
    step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    player_hit = 1'b1;
    push("hit_last", 3'd3, 3'd0, 3'd5, 4'd1);
    step();
    player_hit = 1'b0;
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    push("game_over", 3'd4, 3'd0, 3'd5, 4'd1);
    repeat (8) step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
`ifdef HIGH_SCORE_EN
    checks++;
    if (hi_score !== 3'd5) begin errors++; $display("FAIL hi_capture got=%0d exp=5", hi_score); end
`endif
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    push("to_attract", 3'd0, 3'd0, 3'd5, 4'd1);
    step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    push("restart", 3'd1, 3'd2, 3'd0, 4'd1);
    step();
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    start_btn = 1'b0;
`ifdef HIGH_SCORE_EN
    checks++;
    if (hi_score !== 3'd5) begin errors++; $display("FAIL hi_keep got=%0d exp=5", hi_score); end
`endif
  endtask

  task automatic test_wave_score();
    for (int i = 0; i < 3; i++) begin
      step();
      wave_clear = 1'b1;
      push("wave", 3'd1, 3'd2, 3'd0, (i == 2) ? 4'd1 : 4'(i + 2));
      step();
      wave_clear = 1'b0;
      begin exp_t e = exp_q.pop_front(); checks++;
        if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s%0d got=%h exp=%h", e.name, i, {state, lives, score, wave}, e.v); end end
      checks++;
      if (respawn !== 1'b1) begin errors++; $display("FAIL wave_respawn%0d got=%b exp=1", i, respawn); end
    end
    for (int i = 1; i <= 9; i++) begin
      enemy_killed = 1'b1;
      push("score_sat", 3'd1, 3'd2, (i > 7) ? 3'd7 : SW'(i), 4'd1);
      step();
      begin exp_t e = exp_q.pop_front(); checks++;
        if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s%0d got=%h exp=%h", e.name, i, {state, lives, score, wave}, e.v); end end
    end
    enemy_killed = 1'b0;
  endtask

  task automatic test_reset_dying();
    step();
    player_hit = 1'b1;
    push("hit_rst", 3'd3, 3'd1, 3'd7, 4'd1);
    step();
    player_hit = 1'b0;
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    repeat (3) step();
    rst = 1'b1;
    push("rst_dying", 3'd0, 3'd0, 3'd0, 4'd1);
    step();
    rst = 1'b0;
    begin exp_t e = exp_q.pop_front(); checks++;
      if ({state, lives, score, wave} !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.name, {state, lives, score, wave}, e.v); end end
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (state !== 3'd0 || {play_en, move_tick, bullet_tick, respawn} !== 4'b0) begin
        errors++; $display("FAIL post_rst k=%0d got st=%0d pulses=%b exp st=0 pulses=0000", k, state, {play_en, move_tick, bullet_tick, respawn});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_priority();
    test_game_over();
    test_wave_score();
    test_reset_dying();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
